mac_dot_pipe: RTL and testbench

Parametrised, fully pipelined dot-product engine for the SDR/filter datapath: multiplies N_TAPS element pairs per beat, reduces them through a registered binary adder tree, and accumulates the tree sum over a multi-beat group (first/last framed).
- Generalises the fixed 9-tap unsigned MAC: parametrised tap count and widths, a signed mode, valid/framing sideband, and a saturating group accumulator with overflow and protocol-error flags.
- One beat accepted every cycle; there is no backpressure.

---
 rtl/mac_dot_pipe_if.sv | 31 +++
 rtl/mac_dot_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_mac_dot_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_pipe_if.sv
// Bus bundle for mac_dot_pipe: framed operand beats in, group results and flags out.
interface mac_dot_pipe_if #(
  parameter int N_TAPS = 9,
  parameter int A_W    = 9,
  parameter int B_W    = 9,
  parameter int ACC_W  = 32
);

  logic                    in_valid;
  logic                    in_first;
  logic                    in_last;
  logic [N_TAPS*A_W-1:0]   a;
  logic [N_TAPS*B_W-1:0]   b;
  logic                    out_valid;
  logic [ACC_W-1:0]        out_sum;
  logic                    out_ovf;
  logic                    out_err;

  // Producer side: drives beats, observes results.
  modport master (
    output in_valid, in_first, in_last, a, b,
    input  out_valid, out_sum, out_ovf, out_err
  );

  // Engine side: consumes beats, produces results.
  modport slave (
    input  in_valid, in_first, in_last, a, b,
    output out_valid, out_sum, out_ovf, out_err
  );

endinterface

// File: rtl/mac_dot_pipe.sv
// Pipelined dot-product engine: per-beat element products, registered binary
// adder tree, then a saturating accumulator that sums tree results over a
// first/last framed group. One beat per cycle, no backpressure.
module mac_dot_pipe #(
  parameter int N_TAPS = 9,
  parameter int A_W    = 9,
  parameter int B_W    = 9,
  parameter int SIGNED = 0,
  parameter int ACC_W  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mac_dot_pipe_if.slave bus
);

  localparam int P  = A_W + B_W;
  localparam int D  = $clog2(N_TAPS);
  localparam int NP = 1 << D;
  localparam int TW = P + D;

  localparam logic SX = (SIGNED != 0);

  localparam logic [ACC_W-1:0] U_MAX = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Reject configurations the datapath cannot represent without wrap.
  if (N_TAPS < 2) begin : g_taps_check
    $error("mac_dot_pipe: N_TAPS must be at least 2");
  end
  if (ACC_W < TW) begin : g_acc_w_check
    $error("mac_dot_pipe: ACC_W must be >= A_W+B_W+clog2(N_TAPS)");
  end

  // Extend both operands to the full product width (sign or zero) so the
  // low P bits of the product are exact in either mode.
  function automatic logic [P-1:0] mul_elem(input logic [A_W-1:0] x,
                                            input logic [B_W-1:0] y);
    logic [P-1:0] xe;
    logic [P-1:0] ye;
    xe = {{B_W{x[A_W-1] & SX}}, x};
    ye = {{A_W{y[B_W-1] & SX}}, y};
    return xe * ye;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 0: element products
  // ---------------------------------------------------------------------------
  logic [P-1:0] prod [N_TAPS];

  // Register one product per element pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) prod[i] <= '0;
    end else begin
      for (int i = 0; i < N_TAPS; i++) begin
        prod[i] <= mul_elem(bus.a[i*A_W +: A_W], bus.b[i*B_W +: B_W]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Adder tree. Every level is held at the final tree width; leaves are
  // extended once here, which gives each level the extra headroom bit it
  // needs. Missing leaves up to the next power of two are zero.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] lvl0 [NP];

  for (genvar j = 0; j < NP; j++) begin : g_lvl0
    if (j < N_TAPS) begin : g_leaf
      assign lvl0[j] = {{D{prod[j][P-1] & SX}}, prod[j]};
    end else begin : g_pad
      assign lvl0[j] = '0;
    end
  end

  // tree_r[k] holds level k+1; only the lower NP>>(k+1) entries carry data.
  logic [TW-1:0] tree_r [D][NP];

  // Pairwise reduction, one registered level per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D; k++) begin
        for (int j = 0; j < NP; j++) tree_r[k][j] <= '0;
      end
    end else begin
      for (int j = 0; j < NP / 2; j++) begin
        tree_r[0][j] <= lvl0[2*j] + lvl0[2*j+1];
      end
      for (int k = 1; k < D; k++) begin
        for (int j = 0; j < NP / 2; j++) begin
          tree_r[k][j] <= tree_r[k-1][2*j] + tree_r[k-1][2*j+1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sideband: valid/first/last travel with the data through all 1+D stages.
  // first/last are qualified by valid on entry.
  // ---------------------------------------------------------------------------
  logic [D:0] v_sr;
  logic [D:0] f_sr;
  logic [D:0] l_sr;

  // Shift the framing bits alongside the product and tree stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sr <= '0;
      f_sr <= '0;
      l_sr <= '0;
    end else begin
      v_sr <= {v_sr[D-1:0], bus.in_valid};
      f_sr <= {f_sr[D-1:0], bus.in_valid & bus.in_first};
      l_sr <= {l_sr[D-1:0], bus.in_valid & bus.in_last};
    end
  end

  logic          tv;
  logic          tf;
  logic          tl;
  logic [TW-1:0] tsum;

  assign tv   = v_sr[D];
  assign tf   = f_sr[D];
  assign tl   = l_sr[D];
  assign tsum = tree_r[D-1][0];

  // ---------------------------------------------------------------------------
  // Group accumulator
  // ---------------------------------------------------------------------------
  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } grp_state_t;

  grp_state_t       state;
  grp_state_t       state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic             sticky;
  logic             sticky_nxt;
  logic             err_nxt;
  logic             done_nxt;

  logic             grp_start;
  logic [ACC_W:0]   base_wide;
  logic [ACC_W:0]   tsum_wide;
  logic [ACC_W:0]   sum_wide;
  logic             sat;
  logic [ACC_W-1:0] clamp_val;

  // Next accumulator value, saturation and group framing for the beat
  // leaving the tree. A group starts on a first beat, or on any beat when no
  // group is open (the latter is a framing error, as is a first beat that
  // abandons an open group).
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    sticky_nxt = sticky;
    err_nxt    = 1'b0;
    done_nxt   = 1'b0;

    grp_start  = (state == IDLE) || tf;
    base_wide  = grp_start ? '0 : {acc[ACC_W-1] & SX, acc};
    tsum_wide  = {{(ACC_W + 1 - TW){tsum[TW-1] & SX}}, tsum};
    sum_wide   = base_wide + tsum_wide;

    if (SX) begin
      sat       = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
      clamp_val = sum_wide[ACC_W] ? S_MIN : S_MAX;
    end else begin
      sat       = sum_wide[ACC_W];
      clamp_val = U_MAX;
    end

    if (tv) begin
      err_nxt    = (state == IDLE) ? !tf : tf;
      acc_nxt    = sat ? clamp_val : sum_wide[ACC_W-1:0];
      sticky_nxt = (grp_start ? 1'b0 : sticky) | sat;
      done_nxt   = tl;
      state_nxt  = tl ? IDLE : OPEN;
    end
  end

  // Commit accumulator state and register the result/flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      sticky        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      acc           <= acc_nxt;
      sticky        <= sticky_nxt;
      bus.out_valid <= done_nxt;
      bus.out_ovf   <= done_nxt & sticky_nxt;
      bus.out_err   <= err_nxt;
      if (done_nxt) begin
        bus.out_sum <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_pipe.sv
// Bench for mac_dot_pipe: three configurations (unsigned/32, signed/32,
// unsigned/24) see the same beat stream; a group-level arithmetic model
// predicts every output cycle, and directed cases pin literal results.
module tb_mac_dot_pipe;

  localparam int N    = 9;
  localparam int W    = 9;
  localparam int NCFG = 3;
  localparam int LAT  = 6;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mac_dot_pipe_if #(.N_TAPS(N), .A_W(W), .B_W(W), .ACC_W(32)) bus0 ();
  mac_dot_pipe_if #(.N_TAPS(N), .A_W(W), .B_W(W), .ACC_W(32)) bus1 ();
  mac_dot_pipe_if #(.N_TAPS(N), .A_W(W), .B_W(W), .ACC_W(24)) bus2 ();

  mac_dot_pipe #(.N_TAPS(N), .A_W(W), .B_W(W), .SIGNED(0), .ACC_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  mac_dot_pipe #(.N_TAPS(N), .A_W(W), .B_W(W), .SIGNED(1), .ACC_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  mac_dot_pipe #(.N_TAPS(N), .A_W(W), .B_W(W), .SIGNED(0), .ACC_W(24)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  int cfg_signed [NCFG] = '{0, 1, 0};
  int cfg_accw   [NCFG] = '{32, 32, 24};

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_c = 0;

  // Model state per configuration
  bit     open_m   [NCFG];
  longint acc_m    [NCFG];
  bit     sticky_m [NCFG];

  // Expected outputs indexed by the cycle they must appear in
  bit     exp_v  [NCFG][MAXC];
  bit     exp_e  [NCFG][MAXC];
  bit     exp_o  [NCFG][MAXC];
  longint exp_s  [NCFG][MAXC];

  // Literal expectations from hand-worked cases
  bit     pin_set [NCFG][MAXC];
  longint pin_s   [NCFG][MAXC];
  bit     pin_o   [NCFG][MAXC];
  bit     pin_err [NCFG][MAXC];

  bit [W-1:0] av [N];
  bit [W-1:0] bv [N];

  // Cycle index advanced by every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void cmp(input string name, input int k, input int c,
                              input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("[TB] FAIL %s cfg%0d cycle %0d: got %0d, want %0d", name, k, c, got, want);
    end
  endfunction

  // Group-level model: dot product of the beat, then the framing and
  // saturation rules, recorded against the cycle the result must appear.
  task automatic model_beat(input int c, input bit v, input bit f, input bit l);
    for (int k = 0; k < NCFG; k++) begin
      longint dot, x, y, hi, lo, one, s;
      bit err, start, ov;
      if (!v) continue;
      dot = 0;
      for (int i = 0; i < N; i++) begin
        if (cfg_signed[k] != 0) begin
          x = longint'($signed(av[i]));
          y = longint'($signed(bv[i]));
        end else begin
          x = longint'(av[i]);
          y = longint'(bv[i]);
        end
        dot += x * y;
      end
      one = 1;
      if (cfg_signed[k] != 0) begin
        hi = (one <<< (cfg_accw[k] - 1)) - 1;
        lo = -(one <<< (cfg_accw[k] - 1));
      end else begin
        hi = (one <<< cfg_accw[k]) - 1;
        lo = 0;
      end
      err   = open_m[k] ? f : !f;
      start = !open_m[k] || f;
      s     = (start ? 0 : acc_m[k]) + dot;
      ov    = 1'b0;
      if (s > hi) begin
        s  = hi;
        ov = 1'b1;
      end else if (s < lo) begin
        s  = lo;
        ov = 1'b1;
      end
      sticky_m[k] = (start ? 1'b0 : sticky_m[k]) | ov;
      acc_m[k]    = s;
      if (c + LAT < MAXC) begin
        exp_e[k][c+LAT] = err;
        if (l) begin
          exp_v[k][c+LAT] = 1'b1;
          exp_s[k][c+LAT] = s;
          exp_o[k][c+LAT] = sticky_m[k];
        end
      end
      open_m[k] = !l;
    end
  endtask

  // Drive one beat (valid or not) to all three engines on the falling edge.
  task automatic applyStimulus(input bit v, input bit f, input bit l);
    logic [N*W-1:0] pa, pb;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      pa[i*W +: W] = av[i];
      pb[i*W +: W] = bv[i];
    end
    bus0.in_valid = v; bus0.in_first = f; bus0.in_last = l; bus0.a = pa; bus0.b = pb;
    bus1.in_valid = v; bus1.in_first = f; bus1.in_last = l; bus1.a = pa; bus1.b = pb;
    bus2.in_valid = v; bus2.in_first = f; bus2.in_last = l; bus2.a = pa; bus2.b = pb;
    last_c = cyc;
    model_beat(cyc, v, f, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_ramp(input int bval);
    for (int i = 0; i < N; i++) begin
      av[i] = W'(i + 1);
      bv[i] = W'(bval);
    end
  endtask

  task automatic set_const(input bit [W-1:0] aval, input bit [W-1:0] bval);
    for (int i = 0; i < N; i++) begin
      av[i] = aval;
      bv[i] = bval;
    end
  endtask

  // Pin the result of the group closed by the last beat to a literal.
  task automatic pin_at(input int k, input longint sum, input bit ovf);
    int idx;
    idx = last_c + LAT;
    pin_set[k][idx] = 1'b1;
    pin_s[k][idx]   = sum;
    pin_o[k][idx]   = ovf;
    cmp("model_pin", k, idx, exp_s[k][idx], sum);
  endtask

  task automatic pin_all(input longint sum, input bit ovf);
    for (int k = 0; k < NCFG; k++) pin_at(k, sum, ovf);
  endtask

  task automatic pin_err_all();
    for (int k = 0; k < NCFG; k++) pin_err[k][last_c+LAT] = 1'b1;
  endtask

  task automatic check_reset_state();
    cmp("rst_valid", 0, cyc, longint'(bus0.out_valid), 0);
    cmp("rst_sum",   0, cyc, longint'(bus0.out_sum), 0);
    cmp("rst_ovf",   0, cyc, longint'(bus0.out_ovf), 0);
    cmp("rst_err",   0, cyc, longint'(bus0.out_err), 0);
    cmp("rst_sum",   1, cyc, longint'(bus1.out_sum), 0);
    cmp("rst_sum",   2, cyc, longint'(bus2.out_sum), 0);
    cmp("rst_valid", 2, cyc, longint'(bus2.out_valid), 0);
  endtask

  // Assert reset just after a rising edge; everything in flight is dropped.
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0; bus2.in_valid = 1'b0;
    for (int k = 0; k < NCFG; k++) begin
      open_m[k]   = 1'b0;
      acc_m[k]    = 0;
      sticky_m[k] = 1'b0;
      for (int c = cyc; c < MAXC; c++) begin
        exp_v[k][c]   = 1'b0;
        exp_e[k][c]   = 1'b0;
        pin_set[k][c] = 1'b0;
        pin_err[k][c] = 1'b0;
      end
    end
    @(negedge clk);
    check_reset_state();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Compare one configuration's outputs against the model for this cycle.
  task automatic checkOutput(input int k, input int c, input bit gv, input longint gs,
                             input bit go, input bit ge);
    cmp("out_valid", k, c, longint'(gv), longint'(exp_v[k][c]));
    cmp("out_err",   k, c, longint'(ge), longint'(exp_e[k][c]));
    if (exp_v[k][c]) begin
      cmp("out_sum", k, c, gs, exp_s[k][c]);
      cmp("out_ovf", k, c, longint'(go), longint'(exp_o[k][c]));
    end
    if (pin_set[k][c]) begin
      cmp("pin_valid", k, c, longint'(gv), 1);
      cmp("pin_sum",   k, c, gs, pin_s[k][c]);
      cmp("pin_ovf",   k, c, longint'(go), longint'(pin_o[k][c]));
    end
    if (pin_err[k][c]) cmp("pin_err", k, c, longint'(ge), 1);
  endtask

  // Single compare process: every falling edge, every configuration.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      checkOutput(0, cyc, bus0.out_valid, longint'(bus0.out_sum), bus0.out_ovf, bus0.out_err);
      checkOutput(1, cyc, bus1.out_valid, longint'($signed(bus1.out_sum)), bus1.out_ovf,
                  bus1.out_err);
      checkOutput(2, cyc, bus2.out_valid, longint'(bus2.out_sum), bus2.out_ovf, bus2.out_err);
    end
  end

  initial begin
    bus0.in_valid = 1'b0; bus0.in_first = 1'b0; bus0.in_last = 1'b0; bus0.a = '0; bus0.b = '0;
    bus1.in_valid = 1'b0; bus1.in_first = 1'b0; bus1.in_last = 1'b0; bus1.a = '0; bus1.b = '0;
    bus2.in_valid = 1'b0; bus2.in_first = 1'b0; bus2.in_last = 1'b0; bus2.a = '0; bus2.b = '0;
    for (int k = 0; k < NCFG; k++) begin
      open_m[k] = 1'b0; acc_m[k] = 0; sticky_m[k] = 1'b0;
    end
    set_const('0, '0);

    repeat (2) @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    $display("[TB] single-beat ramp");
    set_ramp(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    pin_all(45, 1'b0);
    idle(8);

    $display("[TB] all-ones operands");
    set_const(9'd511, 9'd511);
    applyStimulus(1'b1, 1'b1, 1'b1);
    pin_at(0, 2350089, 1'b0);
    pin_at(1, 9, 1'b0);
    pin_at(2, 2350089, 1'b0);
    idle(8);

    $display("[TB] signed extreme operands");
    set_const(9'h100, 9'h0FF);
    applyStimulus(1'b1, 1'b1, 1'b1);
    pin_at(0, 587520, 1'b0);
    pin_at(1, -587520, 1'b0);
    pin_at(2, 587520, 1'b0);
    idle(8);

    $display("[TB] three-beat group then back-to-back single");
    set_ramp(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    pin_all(270, 1'b0);
    set_ramp(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    pin_all(45, 1'b0);
    idle(8);

    $display("[TB] saturating group");
    set_const(9'd511, 9'd511);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    pin_at(0, 18800712, 1'b0);
    pin_at(1, 72, 1'b0);
    pin_at(2, 16777215, 1'b1);
    set_ramp(1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    pin_all(45, 1'b0);
    idle(8);

    $display("[TB] framing errors");
    set_ramp(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    pin_err_all();
    applyStimulus(1'b1, 1'b0, 1'b1);
    pin_all(90, 1'b0);
    idle(4);
    applyStimulus(1'b1, 1'b1, 1'b0);
    set_ramp(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    pin_err_all();
    set_ramp(1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    pin_all(135, 1'b0);
    idle(8);

    $display("[TB] reset with beats in flight");
    set_ramp(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    do_reset(2);
    idle(10);
    applyStimulus(1'b1, 1'b1, 1'b1);
    pin_all(45, 1'b0);
    idle(8);

    $display("[TB] random beats");
    for (int n = 0; n < 400; n++) begin
      bit v, f, l;
      if ($urandom_range(2, 0) == 0) begin
        set_const(9'd511, 9'd511);
      end else begin
        for (int i = 0; i < N; i++) begin
          av[i] = W'($urandom_range(511, 0));
          bv[i] = W'($urandom_range(511, 0));
        end
      end
      v = ($urandom_range(3, 0) != 0);
      f = ($urandom_range(3, 0) == 0);
      l = ($urandom_range(3, 0) == 0);
      applyStimulus(v, f, l);
    end
    idle(LAT + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
